// File: rtl/vend_kiosk_arbiter.sv
// vend_kiosk_arbiter: round-robin session arbiter sharing one vending_mac core among N coin kiosks.
module vend_kiosk_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [2*N-1:0] coin,
  input  logic [N-1:0]   coin_vld,
  output logic [N-1:0]   coin_rdy,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   vend_done,
  output logic [1:0]     chg_out,
  output logic           refund_vld,
  output logic [2:0]     refund_amt,
  output logic           busy,
  output logic [1:0]     core_in,
  output logic           core_clr,
  input  logic           core_out,
  input  logic [1:0]     core_change
);
  localparam int LW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE, ABORT} state_t;
  state_t        state_q, state_d;
  logic [LW-1:0] gidx_q, gidx_d, last_q, last_d, pick, idx;
  logic [N-1:0]  grant_q, grant_d, vend_done_q, vend_done_d;
  logic [2:0]    credit_q, credit_d, refund_amt_q, refund_amt_d, add;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    core_in_q, core_in_d, chg_q, chg_d, cur_coin;
  logic          refund_vld_q, refund_vld_d, core_clr_q, core_clr_d, xfer;
  assign coin_rdy   = (state_q == ACTIVE && credit_q < 3'd3) ? grant_q : '0;
  assign grant      = grant_q;
  assign vend_done  = vend_done_q;
  assign chg_out    = chg_q;
  assign refund_vld = refund_vld_q;
  assign refund_amt = refund_amt_q;
  assign busy       = state_q != IDLE;
  assign core_in    = core_in_q;
  assign core_clr   = core_clr_q;
  assign cur_coin   = coin[{gidx_q, 1'b0} +: 2];
  assign xfer       = coin_vld[gidx_q] & coin_rdy[gidx_q];
  assign add        = cur_coin == 2'b01 ? 3'd1 : cur_coin == 2'b10 ? 3'd2 : 3'd0;
  always_comb begin
    pick = last_q;
    idx  = last_q;
    for (int k = N; k >= 1; k--) begin
      idx = LW'((int'(last_q) + k) % N);
      if (req[idx]) pick = idx;
    end
    state_d      = state_q;
    gidx_d       = gidx_q;
    grant_d      = grant_q;
    last_d       = last_q;
    credit_d     = credit_q;
    tmo_d        = tmo_q;
    chg_d        = chg_q;
    core_in_d    = 2'b00;
    vend_done_d  = '0;
    refund_vld_d = 1'b0;
    refund_amt_d = 3'd0;
    core_clr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // No session starts while the core is still held in clear after reset
        if (|req && !core_clr_q) begin
          state_d  = ACTIVE;
          gidx_d   = pick;
          grant_d  = N'(1) << pick;
          credit_d = 3'd0;
          tmo_d    = '0;
        end
      end
      ACTIVE: begin
        credit_d  = credit_q + (xfer ? add : 3'd0);
        tmo_d     = xfer ? '0 : tmo_q + TW'(1);
        core_in_d = (xfer && add != 3'd0) ? cur_coin : 2'b00;
        if (core_out) begin
          state_d     = DONE;
          chg_d       = core_change;
          vend_done_d = grant_q;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d      = ABORT;
          core_clr_d   = 1'b1;
          refund_vld_d = credit_d != 3'd0;
          refund_amt_d = credit_d;
        end else if (!req[gidx_q] && credit_q == 3'd0 && !xfer) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        last_d  = gidx_q;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      gidx_q       <= '0;
      grant_q      <= '0;
      last_q       <= LW'(N - 1);
      credit_q     <= 3'd0;
      tmo_q        <= '0;
      chg_q        <= 2'b00;
      core_in_q    <= 2'b00;
      vend_done_q  <= '0;
      refund_vld_q <= 1'b0;
      refund_amt_q <= 3'd0;
      core_clr_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      gidx_q       <= gidx_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      credit_q     <= credit_d;
      tmo_q        <= tmo_d;
      chg_q        <= chg_d;
      core_in_q    <= core_in_d;
      vend_done_q  <= vend_done_d;
      refund_vld_q <= refund_vld_d;
      refund_amt_q <= refund_amt_d;
      core_clr_q   <= core_clr_d;
    end
  end
endmodule
